// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Operand-forward select encoding and the mul/div sequencing FSM states.
package hazard_ctrl_pkg;

  localparam int RW_DEF    = 5;
  localparam int MDLAT_DEF = 4;
  localparam int CW_DEF    = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Register indices/flags from the pipeline stages into the hazard controller,
// and the register enables, clears, forward selects and perf counters it drives back.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int RW = RW_DEF,
  parameter int CW = CW_DEF
);

  logic [RW-1:0] id_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use1;
  logic          id_use2;
  logic [RW-1:0] ex_rs1;
  logic [RW-1:0] ex_rs2;
  logic [RW-1:0] ex_rd;
  logic          ex_mem_read;
  logic          ex_md_start;
  logic          ex_br_taken;
  logic [RW-1:0] mem_rd;
  logic [RW-1:0] wb_rd;
  logic          mem_reg_wr;
  logic          wb_reg_wr;

  logic          pc_en;
  logic          ifid_en;
  logic          idex_en;
  logic          exmem_en;
  logic          ifid_clr;
  logic          idex_clr;
  logic          exmem_clr;
  fwd_sel_t      fwd_a;
  fwd_sel_t      fwd_b;
  logic          md_busy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_md_start, ex_br_taken, mem_rd, wb_rd, mem_reg_wr, wb_reg_wr,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_clr, idex_clr, exmem_clr,
           fwd_a, fwd_b, md_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use1, id_use2, ex_rs1, ex_rs2, ex_rd,
           ex_mem_read, ex_md_start, ex_br_taken, mem_rd, wb_rd, mem_reg_wr, wb_reg_wr,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_clr, idex_clr, exmem_clr,
           fwd_a, fwd_b, md_busy, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forward-source select for one EX operand; purely combinational.
// MEM result is younger than WB, so it wins; register 0 is never forwarded.
module hazard_ctrl_fwd_sel
  import hazard_ctrl_pkg::*;
#(
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] i_src,
  input  logic [RW-1:0] i_mem_rd,
  input  logic          i_mem_wr,
  input  logic [RW-1:0] i_wb_rd,
  input  logic          i_wb_wr,
  output fwd_sel_t      o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_wr && (i_mem_rd != '0) && (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_wr  && (i_wb_rd  != '0) && (i_wb_rd  == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_mem_hit) begin
      o_sel = FWD_MEM;
    end else if (w_wb_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: zero-latency stall/flush/forward decode from the stage inputs,
// plus the mul/div occupancy FSM and saturating stall/flush perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RW    = RW_DEF,
  parameter int MDLAT = MDLAT_DEF,
  parameter int CW    = CW_DEF
) (
  input logic         i_clk,
  input logic         i_rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int MW = (MDLAT > 2) ? $clog2(MDLAT - 1) : 1;

  hz_state_t     r_state;
  hz_state_t     w_state_nxt;
  logic [MW-1:0] r_md_cnt;
  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] r_flush_cnt;

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;
  logic     w_lu;
  logic     w_md_go;
  logic     w_flush;
  logic     w_pc_en;
  logic     w_ifid_en;
  logic     w_idex_en;
  logic     w_exmem_en;
  logic     w_ifid_clr;
  logic     w_idex_clr;
  logic     w_exmem_clr;
  logic     w_md_busy;

  hazard_ctrl_fwd_sel #(.RW(RW)) u_fwd_a (
    .i_src    (hz.ex_rs1),
    .i_mem_rd (hz.mem_rd),
    .i_mem_wr (hz.mem_reg_wr),
    .i_wb_rd  (hz.wb_rd),
    .i_wb_wr  (hz.wb_reg_wr),
    .o_sel    (w_fwd_a)
  );

  hazard_ctrl_fwd_sel #(.RW(RW)) u_fwd_b (
    .i_src    (hz.ex_rs2),
    .i_mem_rd (hz.mem_rd),
    .i_mem_wr (hz.mem_reg_wr),
    .i_wb_rd  (hz.wb_rd),
    .i_wb_wr  (hz.wb_reg_wr),
    .o_sel    (w_fwd_b)
  );

  assign w_lu = hz.ex_mem_read && (hz.ex_rd != '0) &&
                ((hz.id_use1 && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_use2 && (hz.id_rs2 == hz.ex_rd)));

  // Priority in RUN: taken branch, then mul/div start, then load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_md_go     = 1'b0;
    w_flush     = 1'b0;
    w_md_busy   = 1'b0;
    w_pc_en     = 1'b1;
    w_ifid_en   = 1'b1;
    w_idex_en   = 1'b1;
    w_exmem_en  = 1'b1;
    w_ifid_clr  = 1'b0;
    w_idex_clr  = 1'b0;
    w_exmem_clr = 1'b0;
    if (!i_rst_n) begin
      w_state_nxt = RUN;
      w_pc_en     = 1'b0;
      w_ifid_en   = 1'b0;
      w_idex_en   = 1'b0;
      w_exmem_en  = 1'b0;
      w_ifid_clr  = 1'b1;
      w_idex_clr  = 1'b1;
      w_exmem_clr = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (hz.ex_br_taken) begin
            w_flush    = 1'b1;
            w_ifid_clr = 1'b1;
            w_idex_clr = 1'b1;
          end else if (hz.ex_md_start) begin
            w_md_go     = 1'b1;
            w_state_nxt = MD_WAIT;
            w_pc_en     = 1'b0;
            w_ifid_en   = 1'b0;
            w_idex_en   = 1'b0;
            w_exmem_clr = 1'b1;
          end else if (w_lu) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_clr = 1'b1;
          end
        end
        MD_WAIT: begin
          w_md_busy   = 1'b1;
          w_pc_en     = 1'b0;
          w_ifid_en   = 1'b0;
          w_idex_en   = 1'b0;
          w_exmem_clr = 1'b1;
          if (r_md_cnt == '0) begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= RUN;
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_md_go) begin
        r_md_cnt <= MW'(MDLAT - 2);
      end else if ((r_state == MD_WAIT) && (r_md_cnt != '0)) begin
        r_md_cnt <= r_md_cnt - 1'b1;
      end
      if (!w_pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign hz.pc_en     = w_pc_en;
  assign hz.ifid_en   = w_ifid_en;
  assign hz.idex_en   = w_idex_en;
  assign hz.exmem_en  = w_exmem_en;
  assign hz.ifid_clr  = w_ifid_clr;
  assign hz.idex_clr  = w_idex_clr;
  assign hz.exmem_clr = w_exmem_clr;
  assign hz.fwd_a     = i_rst_n ? w_fwd_a : FWD_RF;
  assign hz.fwd_b     = i_rst_n ? w_fwd_b : FWD_RF;
  assign hz.md_busy   = w_md_busy;
  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand-built mul/div,
// reset-abort and counter-saturation sequences, with an expected-output scoreboard.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int RW    = 5;
  localparam int MDLAT = 4;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          use1;
    logic          use2;
    logic [RW-1:0] ex_rs1;
    logic [RW-1:0] ex_rs2;
    logic [RW-1:0] ex_rd;
    logic          mem_read;
    logic          md_start;
    logic          br;
    logic [RW-1:0] mem_rd;
    logic [RW-1:0] wb_rd;
    logic          mem_wr;
    logic          wb_wr;
  } in_t;

  typedef struct packed {
    logic     pc_en;
    logic     ifid_en;
    logic     idex_en;
    logic     exmem_en;
    logic     ifid_clr;
    logic     idex_clr;
    logic     exmem_clr;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;
    logic     md_busy;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  out_t  sb_q[$];
  string nm_q[$];
  vec_t  tbl[$];

  int exp_stall = 0;
  int exp_flush = 0;
  logic pend_rst = 1'b0;
  logic pend_stall = 1'b0;
  logic pend_flush = 1'b0;

  hazard_ctrl_if #(.RW(RW), .CW(CW)) hz ();

  hazard_ctrl #(.RW(RW), .MDLAT(MDLAT), .CW(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hz)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic out_t o_run(fwd_sel_t a, fwd_sel_t b);
    out_t o;
    o = '0;
    o.pc_en = 1'b1; o.ifid_en = 1'b1; o.idex_en = 1'b1; o.exmem_en = 1'b1;
    o.fwd_a = a; o.fwd_b = b;
    return o;
  endfunction

  function automatic out_t o_lu();
    out_t o;
    o = o_run(FWD_RF, FWD_RF);
    o.pc_en = 1'b0; o.ifid_en = 1'b0; o.idex_clr = 1'b1;
    return o;
  endfunction

  function automatic out_t o_br();
    out_t o;
    o = o_run(FWD_RF, FWD_RF);
    o.ifid_clr = 1'b1; o.idex_clr = 1'b1;
    return o;
  endfunction

  function automatic out_t o_md(logic busy);
    out_t o;
    o = o_run(FWD_RF, FWD_RF);
    o.pc_en = 1'b0; o.ifid_en = 1'b0; o.idex_en = 1'b0; o.exmem_clr = 1'b1;
    o.md_busy = busy;
    return o;
  endfunction

  function automatic out_t o_rst();
    out_t o;
    o = '0;
    o.ifid_clr = 1'b1; o.idex_clr = 1'b1; o.exmem_clr = 1'b1;
    return o;
  endfunction

  function automatic in_t lu_in();
    in_t v;
    v = idle();
    v.mem_read = 1'b1; v.ex_rd = 5'd3; v.id_rs2 = 5'd3; v.use2 = 1'b1;
    return v;
  endfunction

  task automatic add(input string nm, input in_t i, input out_t o);
    vec_t v;
    v.nm = nm; v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  // Counter effects of a cycle become visible after its closing edge.
  task automatic step();
    @(posedge clk);
    if (pend_rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (pend_stall && exp_stall < CMAX) exp_stall++;
      if (pend_flush && exp_flush < CMAX) exp_flush++;
    end
  endtask

  task automatic drive(input in_t v);
    hz.id_rs1 = v.id_rs1;   hz.id_rs2 = v.id_rs2;
    hz.id_use1 = v.use1;    hz.id_use2 = v.use2;
    hz.ex_rs1 = v.ex_rs1;   hz.ex_rs2 = v.ex_rs2;   hz.ex_rd = v.ex_rd;
    hz.ex_mem_read = v.mem_read; hz.ex_md_start = v.md_start; hz.ex_br_taken = v.br;
    hz.mem_rd = v.mem_rd;   hz.wb_rd = v.wb_rd;
    hz.mem_reg_wr = v.mem_wr; hz.wb_reg_wr = v.wb_wr;
  endtask

  task automatic check_out();
    out_t  got;
    out_t  exp;
    string nm;
    got.pc_en = hz.pc_en;       got.ifid_en = hz.ifid_en;
    got.idex_en = hz.idex_en;   got.exmem_en = hz.exmem_en;
    got.ifid_clr = hz.ifid_clr; got.idex_clr = hz.idex_clr;
    got.exmem_clr = hz.exmem_clr;
    got.fwd_a = hz.fwd_a;       got.fwd_b = hz.fwd_b;
    got.md_busy = hz.md_busy;
    exp = sb_q.pop_front();
    nm  = nm_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pc,ifid,idex,exmem_en=%b%b%b%b clr=%b%b%b fa=%b fb=%b busy=%b ; exp %b%b%b%b clr=%b%b%b fa=%b fb=%b busy=%b",
               nm, got.pc_en, got.ifid_en, got.idex_en, got.exmem_en,
               got.ifid_clr, got.idex_clr, got.exmem_clr, got.fwd_a, got.fwd_b, got.md_busy,
               exp.pc_en, exp.ifid_en, exp.idex_en, exp.exmem_en,
               exp.ifid_clr, exp.idex_clr, exp.exmem_clr, exp.fwd_a, exp.fwd_b, exp.md_busy);
    end
  endtask

  task automatic apply(input string nm, input logic rst, input in_t i, input out_t e);
    step();
    #1;
    rst_n = rst;
    drive(i);
    sb_q.push_back(e);
    nm_q.push_back(nm);
    pend_rst   = !rst;
    pend_stall = !e.pc_en;
    pend_flush = e.ifid_clr;
    @(negedge clk);
    check_out();
  endtask

  task automatic chk_cnt(input string nm);
    checks++;
    if (hz.stall_cnt !== CW'(exp_stall)) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d exp %0d", nm, hz.stall_cnt, exp_stall);
    end
    checks++;
    if (hz.flush_cnt !== CW'(exp_flush)) begin
      errors++;
      $display("FAIL %s flush_cnt: got %0d exp %0d", nm, hz.flush_cnt, exp_flush);
    end
  endtask

  initial begin
    in_t v;

    // Forwarding table
    v = idle(); v.ex_rs1 = 5'd5; v.mem_rd = 5'd5; v.mem_wr = 1'b1; v.wb_rd = 5'd5; v.wb_wr = 1'b1;
    add("fwd_mem_beats_wb", v, o_run(FWD_MEM, FWD_RF));
    v.mem_wr = 1'b0;
    add("fwd_wb_only", v, o_run(FWD_WB, FWD_RF));
    v = idle(); v.mem_wr = 1'b1; v.wb_wr = 1'b1;
    add("fwd_reg0_never", v, o_run(FWD_RF, FWD_RF));
    v = idle(); v.ex_rs1 = 5'd6; v.ex_rs2 = 5'd7; v.mem_rd = 5'd6; v.mem_wr = 1'b1;
    v.wb_rd = 5'd7; v.wb_wr = 1'b1;
    add("fwd_a_mem_b_wb", v, o_run(FWD_MEM, FWD_WB));
    v = idle(); v.ex_rs2 = 5'd9; v.mem_rd = 5'd8; v.mem_wr = 1'b1; v.wb_rd = 5'd8; v.wb_wr = 1'b1;
    add("fwd_no_match", v, o_run(FWD_RF, FWD_RF));
    // Load-use table
    add("lu_rs2", lu_in(), o_lu());
    v = lu_in(); v.use2 = 1'b0;
    add("lu_rs2_unused", v, o_run(FWD_RF, FWD_RF));
    v = idle(); v.mem_read = 1'b1; v.ex_rd = 5'd4; v.id_rs1 = 5'd4; v.use1 = 1'b1;
    add("lu_rs1", v, o_lu());
    v = idle(); v.mem_read = 1'b1; v.use1 = 1'b1;
    add("lu_rd0_ignored", v, o_run(FWD_RF, FWD_RF));
    v = lu_in(); v.id_rs2 = 5'd2;
    add("lu_no_match", v, o_run(FWD_RF, FWD_RF));
    // Branch table
    v = lu_in(); v.br = 1'b1;
    add("br_over_lu", v, o_br());
    v = idle(); v.br = 1'b1; v.md_start = 1'b1;
    add("br_over_mdstart", v, o_br());
    add("after_br_md_idle", idle(), o_run(FWD_RF, FWD_RF));

    // Reset state, with forwarding-capable inputs present
    v = idle(); v.ex_rs1 = 5'd5; v.mem_rd = 5'd5; v.mem_wr = 1'b1; v.br = 1'b1;
    rst_n = 1'b0;
    drive(v);
    apply("reset_0", 1'b0, v, o_rst());
    apply("reset_1", 1'b0, v, o_rst());
    chk_cnt("reset");

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].nm, 1'b1, tbl[k].i, tbl[k].o);
    end
    apply("tbl_tail_idle", 1'b1, idle(), o_run(FWD_RF, FWD_RF));
    chk_cnt("after_table");

    // Mul/div: 4 stall cycles, busy for last 3; branch/LU inside MD_WAIT ignored
    v = idle(); v.md_start = 1'b1;
    apply("md_start", 1'b1, v, o_md(1'b0));
    apply("md_wait_1", 1'b1, idle(), o_md(1'b1));
    v = lu_in(); v.br = 1'b1; v.md_start = 1'b1;
    apply("md_wait_2_br_ignored", 1'b1, v, o_md(1'b1));
    apply("md_wait_3", 1'b1, idle(), o_md(1'b1));
    apply("md_done_run", 1'b1, idle(), o_run(FWD_RF, FWD_RF));
    chk_cnt("after_md");

    // Reset in second MD_WAIT cycle abandons the op
    v = idle(); v.md_start = 1'b1;
    apply("md2_start", 1'b1, v, o_md(1'b0));
    apply("md2_wait_1", 1'b1, idle(), o_md(1'b1));
    apply("md2_reset", 1'b0, idle(), o_rst());
    apply("md2_after_reset", 1'b1, idle(), o_run(FWD_RF, FWD_RF));
    chk_cnt("md_reset_abort");

    // Stall-counter saturation under a held load-use hazard
    apply("sat_lu_first", 1'b1, lu_in(), o_lu());
    for (int k = 0; k < CMAX - 1; k++) step();
    @(negedge clk);
    chk_cnt("sat_minus1");
    step();
    @(negedge clk);
    chk_cnt("sat_at_max");
    for (int k = 0; k < 5; k++) step();
    @(negedge clk);
    chk_cnt("sat_hold");
    checks++;
    if (hz.stall_cnt !== '1) begin
      errors++;
      $display("FAIL sat_no_wrap: got %0d exp %0d", hz.stall_cnt, CMAX);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
